// File: rtl/alu_pkg.sv
// Shared definitions for the execution stage and the register-file write-back decode.
package alu_pkg;

   // Opcodes carried in instruction bits [7:5]
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_ADDI = 3'b110;
   localparam logic [2:0] OP_SUBI = 3'b111;

   // MUL/DIV iteration count; equals the operand width
   localparam int unsigned ALU_ITER = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // MUL and DIV take the iterative path; everything else completes in one clock
   function automatic logic is_muldiv(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/shift_muldiv_unit.sv
// Iterative shift-add multiplier and restoring divider sharing one step counter.
module shift_muldiv_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ITER  = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [2:0]         op_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               last_o,
   output logic               is_div_o,
   output logic               div_zero_o,
   output logic [2*WIDTH-1:0] result_o
);

   localparam int unsigned CntW = $clog2(ITER + 1);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   divisor_q;
   logic               is_div_q;
   logic               div_zero_q;
   logic [CntW-1:0]    count_q;
   logic [WIDTH:0]     trial;
   logic [WIDTH:0]     diff;
   logic               ge;

   // Next value of both datapaths for the current step
   always_comb begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      // Partial remainder stays below the divisor, so a set borrow bit means trial < divisor
      trial    = {rem_q, quo_q[WIDTH-1]};
      diff     = trial - {1'b0, divisor_q};
      ge       = ~diff[WIDTH];
      rem_d    = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_d    = {quo_q[WIDTH-2:0], ge};
   end

   // Result as it will stand after this step; sampled by the top on the last step
   always_comb begin
      if (!is_div_q) begin
         result_o = acc_d;
      end else if (div_zero_q) begin
         result_o = {quo_q, {WIDTH{1'b1}}};
      end else begin
         result_o = {rem_d, quo_d};
      end
   end

   assign last_o     = (count_q == CntW'(ITER - 1));
   assign is_div_o   = is_div_q;
   assign div_zero_o = div_zero_q;

   // Operand load and per-step register update
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         divisor_q  <= '0;
         is_div_q   <= 1'b0;
         div_zero_q <= 1'b0;
         count_q    <= '0;
      end else if (load_i) begin
         acc_q      <= '0;
         mcand_q    <= {{WIDTH{1'b0}}, a_i};
         mplier_q   <= b_i;
         rem_q      <= '0;
         quo_q      <= a_i;
         divisor_q  <= b_i;
         is_div_q   <= (op_i == OP_DIV);
         div_zero_q <= (op_i == OP_DIV) && (b_i == '0);
         count_q    <= '0;
      end else if (step_i) begin
         count_q <= count_q + 1'b1;
         if (is_div_q) begin
            // Divide-by-zero keeps the dividend parked in quo_q for the result
            if (!div_zero_q) begin
               rem_q <= rem_d;
               quo_q <= quo_d;
            end
         end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
         end
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// Execution stage: single-cycle logic/arithmetic plus an 8-clock MUL/DIV with Start/Busy/Done.
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ITER  = alu_pkg::ALU_ITER
) (
   input  logic               CLK_In,
   input  logic               RST_In,
   input  logic               Start,
   input  logic [WIDTH-1:0]   OperandA,
   input  logic [WIDTH-1:0]   OperandB,
   input  logic [2:0]         Instruction_alu,
   output logic [2*WIDTH-1:0] Result,
   output logic               Busy,
   output logic               Done,
   output logic               Zero,
   output logic               Carry,
   output logic               DivZero
);

   state_e             state_q, state_d;
   logic [2*WIDTH-1:0] result_q;
   logic               zero_q, carry_q, divzero_q;
   logic               accept, is_md;
   logic               md_last, md_is_div, md_divz;
   logic [2*WIDTH-1:0] md_result;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   diff;
   logic [2*WIDTH-1:0] sc_result;
   logic               sc_carry;

   // Start is ignored while iterating
   assign accept = Start && (state_q != S_EXEC);
   assign is_md  = is_muldiv(Instruction_alu);

   shift_muldiv_unit #(
      .WIDTH (WIDTH),
      .ITER  (ITER)
   ) u_muldiv (
      .clk_i      (CLK_In),
      .rst_i      (RST_In),
      .load_i     (accept && is_md),
      .step_i     (state_q == S_EXEC),
      .op_i       (Instruction_alu),
      .a_i        (OperandA),
      .b_i        (OperandB),
      .last_o     (md_last),
      .is_div_o   (md_is_div),
      .div_zero_o (md_divz),
      .result_o   (md_result)
   );

   // State register
   always_ff @(posedge CLK_In or posedge RST_In) begin
      if (RST_In) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: IDLE and DONE both accept a new request
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d = is_md ? S_EXEC : S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            if (md_last) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      Busy = (state_q == S_EXEC);
      Done = (state_q == S_DONE);
   end

   // Single-cycle op results
   always_comb begin
      sum       = {1'b0, OperandA} + {1'b0, OperandB};
      diff      = OperandA - OperandB;
      sc_result = '0;
      sc_carry  = 1'b0;
      unique case (Instruction_alu)
         OP_ADD, OP_ADDI: begin
            sc_result = {{(WIDTH-1){1'b0}}, sum};
            sc_carry  = sum[WIDTH];
         end
         OP_SUB, OP_SUBI: begin
            sc_result = {{WIDTH{1'b0}}, diff};
            sc_carry  = (OperandA < OperandB);
         end
         OP_AND: sc_result = {{WIDTH{1'b0}}, OperandA & OperandB};
         OP_OR:  sc_result = {{WIDTH{1'b0}}, OperandA | OperandB};
         OP_MUL, OP_DIV: ;
      endcase
   end

   // Result and flag registers hold between completions
   always_ff @(posedge CLK_In or posedge RST_In) begin
      if (RST_In) begin
         result_q  <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         divzero_q <= 1'b0;
      end else if (accept && !is_md) begin
         result_q <= sc_result;
         carry_q  <= sc_carry;
         zero_q   <= (sc_result[WIDTH-1:0] == '0);
      end else if ((state_q == S_EXEC) && md_last) begin
         result_q <= md_result;
         carry_q  <= 1'b0;
         zero_q   <= md_is_div ? (md_result[WIDTH-1:0] == '0) : (md_result == '0);
         if (md_is_div) divzero_q <= md_divz;
      end
   end

   assign Result  = result_q;
   assign Zero    = zero_q;
   assign Carry   = carry_q;
   assign DivZero = divzero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and model-checked bench for multicycle_alu.
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  a, b;
   logic [2:0]  op;
   logic [15:0] result;
   logic        busy, done, zero, carry, divzero;

   int n_vec = 0;
   int n_err = 0;

   multicycle_alu #(
      .WIDTH (8),
      .ITER  (8)
   ) dut (
      .CLK_In          (clk),
      .RST_In          (rst),
      .Start           (start),
      .OperandA        (a),
      .OperandB        (b),
      .Instruction_alu (op),
      .Result          (result),
      .Busy            (busy),
      .Done            (done),
      .Zero            (zero),
      .Carry           (carry),
      .DivZero         (divzero)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Issue one op from a point just after an edge; lat = edges after the accept edge until Done
   task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         if (done) begin
            lat = n;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = 8'hA5; b = 8'h5A; op = 3'b010;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({result, busy, done, zero, carry, divzero} !== 21'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got res=%h busy=%b done=%b z=%b c=%b dz=%b want all 0",
                  result, busy, done, zero, carry, divzero);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add_sub();
      int lat;
      do_op(3'b000, 8'hC8, 8'h64, lat);
      n_vec++;
      if (lat !== 0) begin n_err++; $display("FAIL add_latency: got %0d want 0", lat); end
      n_vec++;
      if ({result, carry, zero} !== {16'h012C, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL add: got res=%h c=%b z=%b want 012c c=1 z=0", result, carry, zero);
      end
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL add_busy: got %b want 0", busy); end
      do_op(3'b001, 8'h03, 8'h05, lat);
      n_vec++;
      if ({result, carry, zero} !== {16'h00FE, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL sub: got res=%h c=%b z=%b want 00fe c=1 z=0", result, carry, zero);
      end
      do_op(3'b100, 8'hF0, 8'h3C, lat);
      n_vec++;
      if ({result, carry} !== {16'h0030, 1'b0}) begin
         n_err++;
         $display("FAIL and: got res=%h c=%b want 0030 c=0", result, carry);
      end
      do_op(3'b101, 8'h00, 8'h00, lat);
      n_vec++;
      if ({result, zero} !== {16'h0000, 1'b1}) begin
         n_err++;
         $display("FAIL or_zero: got res=%h z=%b want 0000 z=1", result, zero);
      end
      do_op(3'b110, 8'h80, 8'h80, lat);
      n_vec++;
      if ({result, carry, zero} !== {16'h0100, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL addi: got res=%h c=%b z=%b want 0100 c=1 z=1", result, carry, zero);
      end
      do_op(3'b111, 8'h05, 8'h05, lat);
      n_vec++;
      if ({result, carry, zero} !== {16'h0000, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL subi: got res=%h c=%b z=%b want 0000 c=0 z=1", result, carry, zero);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      int lat;
      op = 3'b010; a = 8'hFF; b = 8'hFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 8'h00; b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if ({busy, done} !== 2'b10) begin
            n_err++;
            $display("FAIL mul_busy[%0d]: got busy=%b done=%b want busy=1 done=0", i, busy, done);
         end
         @(posedge clk); #1;
      end
      n_vec++;
      if ({busy, done} !== 2'b01) begin
         n_err++;
         $display("FAIL mul_done: got busy=%b done=%b want busy=0 done=1", busy, done);
      end
      n_vec++;
      if ({result, carry, zero} !== {16'hFE01, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL mul_ff: got res=%h c=%b z=%b want fe01 c=0 z=0", result, carry, zero);
      end
      @(posedge clk); #1;
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL mul_done_pulse: got %b want 0", done); end
      do_op(3'b010, 8'h00, 8'h37, lat);
      n_vec++;
      if (lat !== 8) begin n_err++; $display("FAIL mul0_latency: got %0d want 8", lat); end
      n_vec++;
      if ({result, zero} !== {16'h0000, 1'b1}) begin
         n_err++;
         $display("FAIL mul0: got res=%h z=%b want 0000 z=1", result, zero);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_div();
      int lat;
      do_op(3'b011, 8'hC8, 8'h07, lat);
      n_vec++;
      if (lat !== 8) begin n_err++; $display("FAIL div_latency: got %0d want 8", lat); end
      n_vec++;
      if ({result, divzero, zero} !== {16'h041C, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL div: got res=%h dz=%b z=%b want 041c dz=0 z=0", result, divzero, zero);
      end
      do_op(3'b011, 8'h5A, 8'h00, lat);
      n_vec++;
      if (lat !== 8) begin n_err++; $display("FAIL div0_latency: got %0d want 8", lat); end
      n_vec++;
      if ({result, divzero, zero} !== {16'h5AFF, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL div0: got res=%h dz=%b z=%b want 5aff dz=1 z=0", result, divzero, zero);
      end
      do_op(3'b000, 8'h01, 8'h01, lat);
      n_vec++;
      if ({result, divzero} !== {16'h0002, 1'b1}) begin
         n_err++;
         $display("FAIL divzero_hold: got res=%h dz=%b want 0002 dz=1", result, divzero);
      end
      do_op(3'b011, 8'h10, 8'h03, lat);
      n_vec++;
      if ({result, divzero} !== {16'h0105, 1'b0}) begin
         n_err++;
         $display("FAIL div_clear: got res=%h dz=%b want 0105 dz=0", result, divzero);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat;
      op = 3'b010; a = 8'h03; b = 8'h05; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      op = 3'b000; a = 8'h01; b = 8'h01; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_vec++;
      if ({busy, done} !== 2'b10) begin
         n_err++;
         $display("FAIL ignore_start: got busy=%b done=%b want busy=1 done=0", busy, done);
      end
      lat = -1;
      for (int n = 3; n < 20; n++) begin
         if (done) begin
            lat = n;
            break;
         end
         @(posedge clk); #1;
      end
      n_vec++;
      if (lat !== 8) begin n_err++; $display("FAIL ignore_latency: got %0d want 8", lat); end
      n_vec++;
      if (result !== 16'h000F) begin
         n_err++;
         $display("FAIL ignore_result: got %h want 000f", result);
      end
      op = 3'b000; a = 8'h10; b = 8'h20; start = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if ({done, result} !== {1'b1, 16'h0030}) begin
         n_err++;
         $display("FAIL b2b_add: got done=%b res=%h want done=1 res=0030", done, result);
      end
      op = 3'b101; a = 8'h0F; b = 8'hF0;
      @(posedge clk); #1;
      n_vec++;
      if ({done, result} !== {1'b1, 16'h00FF}) begin
         n_err++;
         $display("FAIL b2b_or: got done=%b res=%h want done=1 res=00ff", done, result);
      end
      op = 3'b010; a = 8'h02; b = 8'h02;
      @(posedge clk); #1;
      start = 1'b0;
      n_vec++;
      if ({busy, done} !== 2'b10) begin
         n_err++;
         $display("FAIL b2b_mul_start: got busy=%b done=%b want busy=1 done=0", busy, done);
      end
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         if (done) begin
            lat = n;
            break;
         end
         @(posedge clk); #1;
      end
      n_vec++;
      if ({lat == 8, result} !== {1'b1, 16'h0004}) begin
         n_err++;
         $display("FAIL b2b_mul: got lat=%0d res=%h want lat=8 res=0004", lat, result);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      int  lat;
      logic seen;
      do_op(3'b011, 8'h11, 8'h00, lat);
      do_op(3'b000, 8'hFF, 8'hFF, lat);
      n_vec++;
      if ({result, carry, divzero} !== {16'h01FE, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL pre_reset: got res=%h c=%b dz=%b want 01fe c=1 dz=1",
                  result, carry, divzero);
      end
      op = 3'b010; a = 8'hAB; b = 8'hCD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({result, busy, done, zero, carry, divzero} !== 21'd0) begin
         n_err++;
         $display("FAIL async_reset: got res=%h busy=%b done=%b z=%b c=%b dz=%b want all 0",
                  result, busy, done, zero, carry, divzero);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL aborted_done: got activity=%b want 0", seen);
      end
      do_op(3'b010, 8'h12, 8'h34, lat);
      n_vec++;
      if ({lat == 8, result} !== {1'b1, 16'h03A8}) begin
         n_err++;
         $display("FAIL post_reset_mul: got lat=%0d res=%h want lat=8 res=03a8", lat, result);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int          lat, exp_lat;
      logic [2:0]  o;
      logic [7:0]  x, y;
      logic [8:0]  s9;
      logic [15:0] exp_res;
      logic        exp_c, exp_z;
      logic        model_dz;
      model_dz = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         o = 3'($urandom_range(0, 7));
         x = 8'($urandom);
         y = 8'($urandom);
         if ($urandom_range(0, 7) == 0) y = 8'h00;
         exp_c   = 1'b0;
         exp_lat = 0;
         case (o)
            3'b000, 3'b110: begin
               s9 = {1'b0, x} + {1'b0, y};
               exp_res = {7'b0, s9};
               exp_c   = s9[8];
            end
            3'b001, 3'b111: begin
               exp_res = {8'h00, 8'(x - y)};
               exp_c   = (x < y);
            end
            3'b010: begin
               exp_res = {8'h00, x} * {8'h00, y};
               exp_lat = 8;
            end
            3'b011: begin
               if (y == 8'h00) begin
                  exp_res  = {x, 8'hFF};
                  model_dz = 1'b1;
               end else begin
                  exp_res  = {8'(x % y), 8'(x / y)};
                  model_dz = 1'b0;
               end
               exp_lat = 8;
            end
            3'b100:  exp_res = {8'h00, x & y};
            default: exp_res = {8'h00, x | y};
         endcase
         exp_z = (o == 3'b010) ? (exp_res == 16'h0000) : (exp_res[7:0] == 8'h00);
         do_op(o, x, y, lat);
         n_vec++;
         if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL rnd%0d_latency op=%b: got %0d want %0d", i, o, lat, exp_lat);
         end
         n_vec++;
         if (result !== exp_res) begin
            n_err++;
            $display("FAIL rnd%0d_result op=%b a=%h b=%h: got %h want %h",
                     i, o, x, y, result, exp_res);
         end
         n_vec++;
         if (carry !== exp_c) begin
            n_err++;
            $display("FAIL rnd%0d_carry op=%b: got %b want %b", i, o, carry, exp_c);
         end
         n_vec++;
         if (zero !== exp_z) begin
            n_err++;
            $display("FAIL rnd%0d_zero op=%b: got %b want %b", i, o, zero, exp_z);
         end
         n_vec++;
         if (divzero !== model_dz) begin
            n_err++;
            $display("FAIL rnd%0d_divzero op=%b: got %b want %b", i, o, divzero, model_dz);
         end
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_mul();
      test_div();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
